data_mem_ctr: RTL

- Memory-side responder for the pipeline's memory-access stage.
- Accepts load/store requests (address, right-justified store value, op bit, access size) and services them against an internal word-organised data RAM after a configurable wait latency.
- Returns right-justified raw load data for the stage to sign- or zero-extend.
- Raises a stall (`o_busy`) to the pipeline while an access is outstanding.

---
 rtl/data_mem_ctr_if.sv | 21 ++
 rtl/data_mem_ctr.sv | 132 +++++++++++++
 2 files changed

// File: rtl/data_mem_ctr_if.sv
// Request/response bus between the memory-access stage and data_mem_ctr.
//   master : pipeline side, drives the request and reads back data/ack/stall
//   slave  : controller side
//   i_req/i_op/i_addr/i_val/i_size : request (held until o_ack)
//   o_val/o_ack/o_err/o_busy      : load data, completion pulse, error, stall
interface data_mem_ctr_if;
  logic        i_req;
  logic        i_op;
  logic [31:0] i_addr;
  logic [31:0] i_val;
  logic [1:0]  i_size;
  logic [31:0] o_val;
  logic        o_ack;
  logic        o_err;
  logic        o_busy;

  modport master (output i_req, i_op, i_addr, i_val, i_size,
                  input  o_val, o_ack, o_err, o_busy);
  modport slave  (input  i_req, i_op, i_addr, i_val, i_size,
                  output o_val, o_ack, o_err, o_busy);
endinterface

// File: rtl/data_mem_ctr.sv
// Memory-side responder for the memory-access stage. Services byte/half/word
// loads and stores against an internal word-organised RAM after LATENCY wait
// cycles; load data comes back right-justified and zero-filled.
//   clk, rst_n : clock, async active-low reset
//   bus        : data_mem_ctr_if.slave (request in, o_val/o_ack/o_err/o_busy out)
module data_mem_ctr #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_ctr_if.slave  bus
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic            op_q;
  logic [AW-1:0]   widx_q;   // only the in-range word index is kept; range is checked at capture
  logic [1:0]      off_q;
  logic [31:0]     val_q;
  logic [1:0]      size_q;
  logic            err_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     o_val_q;
  logic            req_err;
  logic            access;
  logic [3:0]      be, be_sh;
  logic [31:0]     wdata, rdata;

  logic [31:0] mem [DEPTH_WORDS];

  // Request error: bad size, misaligned half/word, or word index out of range.
  always_comb begin
    req_err = 1'b0;
    case (bus.i_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = bus.i_addr[0];
      2'b10:   req_err = |bus.i_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (bus.i_addr[31:2] >= 30'(DEPTH_WORDS)) req_err = 1'b1;
  end

  assign access = (state == WAIT) && (cnt_q == '0);

  // Byte lanes and data alignment; alignment was already checked, so a half
  // never crosses the word boundary.
  always_comb begin
    case (size_q)
      2'b00:   be = 4'b0001;
      2'b01:   be = 4'b0011;
      default: be = 4'b1111;
    endcase
    be_sh = be << off_q;
    wdata = val_q << {off_q, 3'b000};
    rdata = mem[widx_q] >> {off_q, 3'b000};
    case (size_q)
      2'b00:   rdata = rdata & 32'h0000_00ff;
      2'b01:   rdata = rdata & 32'h0000_ffff;
      default: ;
    endcase
  end

  // RAM: not reset. Reset forces IDLE, so an aborted store never reaches here.
  always_ff @(posedge clk) begin
    if (access && op_q) begin
      for (int b = 0; b < 4; b++)
        if (be_sh[b]) mem[widx_q][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_req) state_nxt = req_err ? DONE : WAIT;
      WAIT:    if (cnt_q == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.o_ack  = (state == DONE);
    bus.o_err  = (state == DONE) && err_q;
    bus.o_busy = ((state == IDLE) && bus.i_req) || (state == WAIT);
  end

  assign bus.o_val = o_val_q;

  // Request capture, wait counter and load data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 1'b0;
      widx_q  <= '0;
      off_q   <= '0;
      val_q   <= '0;
      size_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      o_val_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.i_req) begin
          op_q   <= bus.i_op;
          widx_q <= bus.i_addr[AW+1:2];
          off_q  <= bus.i_addr[1:0];
          val_q  <= bus.i_val;
          size_q <= bus.i_size;
          err_q  <= req_err;
          if (!req_err)         cnt_q   <= CW'(LATENCY);
          if (req_err && !bus.i_op) o_val_q <= '0;
        end
        WAIT: begin
          if (cnt_q != '0) cnt_q   <= cnt_q - 1'b1;
          else if (!op_q)  o_val_q <= rdata;
        end
        default: ;
      endcase
    end
  end
endmodule
